// File: rtl/banked_operational_memory_if.sv
// Request/response bundle for the banked operational memory: mode request,
// fetch port (read-only) and data port (read/write with byte enables).
// The master drives requests; the slave (the memory) returns ready and responses.
interface banked_operational_memory_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic                  operationMode;
  logic                  ready;
  logic                  fetchRden;
  logic [ADDR_W-1:0]     fetchAddress;
  logic [DATA_W-1:0]     fetchOutput;
  logic                  fetchValid;
  logic [ADDR_W-1:0]     memAccessAddress;
  logic                  memAccessRden;
  logic                  memAccessWren;
  logic [DATA_W/8-1:0]   memAccessByteEn;
  logic [DATA_W-1:0]     memAccessData;
  logic [DATA_W-1:0]     memAccessOutput;
  logic                  memAccessValid;
  logic                  memAccessFault;

  modport master (
    output operationMode, fetchRden, fetchAddress,
    output memAccessAddress, memAccessRden, memAccessWren, memAccessByteEn, memAccessData,
    input  ready, fetchOutput, fetchValid, memAccessOutput, memAccessValid, memAccessFault
  );

  modport slave (
    input  operationMode, fetchRden, fetchAddress,
    input  memAccessAddress, memAccessRden, memAccessWren, memAccessByteEn, memAccessData,
    output ready, fetchOutput, fetchValid, memAccessOutput, memAccessValid, memAccessFault
  );
endinterface

// File: rtl/banked_operational_memory.sv
// Two-bank (user/kernel) memory with a fetch port and a byte-writable data port.
// Latency: request sampled at edge N, response registered at edge N+1 (one RAM stage).
// Backpressure: ready drops for one SWITCH cycle on a mode change and during reset.
module banked_operational_memory #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int KERN_ADDR_W = 15,
  parameter     USER_INIT   = "RAM.mif"
) (
  input logic clk,
  input logic rst,
  banked_operational_memory_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  // User-bank preload is attached by the implementation flow (memory init
  // attribute / IP wrapper); the RTL itself carries no initial block.
  if ($bits(USER_INIT) == 0) begin : g_no_user_init
  end

  typedef enum logic {RUN = 1'b0, SWITCH = 1'b1} state_t;

  state_t state, next_state;
  logic   active_mode;

  logic [DATA_W-1:0] user_mem [2**ADDR_W];
  logic [DATA_W-1:0] kern_mem [2**KERN_ADDR_W];

  logic [DATA_W-1:0] user_f_q, user_d_q, kern_f_q, kern_d_q;
  logic              f_pend, f_kern, f_oor;
  logic              d_pend, d_kern, d_fault, d_rd;

  logic              accept, fetch_acc, mem_acc, wr_req;
  logic              fetch_oor, mem_oor, user_we, kern_we;
  logic [KERN_ADDR_W-1:0] kern_f_addr, kern_d_addr;

  // Acceptance and fault qualification, all steered by the registered mode
  assign accept      = bus.ready;
  assign fetch_oor   = active_mode & (|(bus.fetchAddress >> KERN_ADDR_W));
  assign mem_oor     = active_mode & (|(bus.memAccessAddress >> KERN_ADDR_W));
  assign wr_req      = bus.memAccessWren & (|bus.memAccessByteEn);
  assign fetch_acc   = accept & bus.fetchRden;
  assign mem_acc     = accept & (bus.memAccessRden | wr_req);
  assign user_we     = mem_acc & wr_req & ~active_mode;
  assign kern_we     = mem_acc & wr_req & active_mode & ~mem_oor;
  assign kern_f_addr = bus.fetchAddress[KERN_ADDR_W-1:0];
  assign kern_d_addr = bus.memAccessAddress[KERN_ADDR_W-1:0];

  // Mode FSM state and active bank register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      active_mode <= 1'b0;
    end else begin
      state <= next_state;
      if (state == SWITCH) active_mode <= bus.operationMode;
    end
  end

  // Mode FSM next state and ready; a mismatch seen in RUN still accepts that cycle
  always_comb begin
    next_state = state;
    bus.ready  = 1'b0;
    case (state)
      RUN: begin
        bus.ready = ~rst;
        if (bus.operationMode != active_mode) next_state = SWITCH;
      end
      SWITCH:  next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  // User bank: read-before-write on both ports, byte-masked writes
  always_ff @(posedge clk) begin
    user_f_q <= user_mem[bus.fetchAddress];
    user_d_q <= user_mem[bus.memAccessAddress];
    if (user_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.memAccessByteEn[i]) user_mem[bus.memAccessAddress][8*i +: 8] <= bus.memAccessData[8*i +: 8];
      end
    end
  end

  // Kernel bank: independent storage, writes suppressed on out-of-range addresses
  always_ff @(posedge clk) begin
    kern_f_q <= kern_mem[kern_f_addr];
    kern_d_q <= kern_mem[kern_d_addr];
    if (kern_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.memAccessByteEn[i]) kern_mem[kern_d_addr][8*i +: 8] <= bus.memAccessData[8*i +: 8];
      end
    end
  end

  // Request stage: remember which bank and fault status each accepted request had
  always_ff @(posedge clk) begin
    if (rst) begin
      f_pend  <= 1'b0;
      d_pend  <= 1'b0;
      f_kern  <= 1'b0;
      f_oor   <= 1'b0;
      d_kern  <= 1'b0;
      d_fault <= 1'b0;
      d_rd    <= 1'b0;
    end else begin
      f_pend  <= fetch_acc;
      d_pend  <= mem_acc;
      f_kern  <= active_mode;
      f_oor   <= fetch_oor;
      d_kern  <= active_mode;
      d_fault <= mem_oor;
      d_rd    <= bus.memAccessRden;
    end
  end

  // Response stage: mux by the registered bank; data holds until the next accepted read
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fetchValid      <= 1'b0;
      bus.fetchOutput     <= '0;
      bus.memAccessValid  <= 1'b0;
      bus.memAccessFault  <= 1'b0;
      bus.memAccessOutput <= '0;
    end else begin
      bus.fetchValid     <= f_pend;
      bus.memAccessValid <= d_pend;
      if (f_pend) bus.fetchOutput <= f_oor ? '0 : (f_kern ? kern_f_q : user_f_q);
      if (d_pend) begin
        bus.memAccessFault <= d_fault;
        if (d_rd) bus.memAccessOutput <= d_fault ? '0 : (d_kern ? kern_d_q : user_d_q);
      end
    end
  end
endmodule
